// File: rtl/seq_sum_pkg.sv
// Shared types and sizes for the sequential sum engine and its display mux.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_sum_pkg;

  // Operand width, operand-count width, accumulator width.
  // The accumulator is DATA_W+CNT_W bits wide, so the largest sum
  // (255 * 0xFFFF) always fits and no saturation is required.
  localparam int DATA_W     = 16;
  localparam int CNT_W      = 8;
  localparam int SUM_W      = DATA_W + CNT_W;
  localparam int NUM_DIGITS = 6;
  localparam int HEX_W      = NUM_DIGITS * 4;

  // Run-control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_sum_engine_hex_digit_select.sv
// Chooses what the six HEX digits show: the running sum, or a status view.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the display follows disp_sel and state immediately.
module hex_digit_select
  import seq_sum_pkg::*;
(
  input  logic              disp_sel,
  input  logic [SUM_W-1:0]  sum,
  input  logic [CNT_W-1:0]  accepted,
  input  logic [DATA_W-1:0] last_op,
  output logic [HEX_W-1:0]  hex_digits
);

  // Status view packs the operand count into HEX5..HEX4 and the most
  // recently accepted operand into HEX3..HEX0.
  always_comb begin
    hex_digits = '0;
    if (disp_sel) begin
      hex_digits = {accepted, last_op};
    end else begin
      hex_digits = sum;
    end
  end

endmodule

// File: rtl/seq_sum_engine.sv
// Accumulates a commanded number of unsigned operands and holds the result.
// Latency: start -> in_ready 1 cycle; final accept -> done (with sum) 1 cycle.
// Backpressure: in_ready only in ACCUM; operand stream may stall indefinitely.
module seq_sum_engine
  import seq_sum_pkg::*;
(
  input  logic              clock,
  input  logic              resetN,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              disp_sel,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic [HEX_W-1:0]  hex_digits
);

  state_t             state_q;
  state_t             state_d;

  logic [SUM_W-1:0]   sum_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [CNT_W-1:0]   accepted_q;
  logic [DATA_W-1:0]  last_op_q;

  // A new run may be launched from IDLE or DONE; start is ignored in ACCUM
  // so an in-flight run cannot be disturbed.
  logic               start_take;
  // An operand is consumed whenever the engine is in ACCUM and the source
  // offers one; in_ready is unconditionally high in that state.
  logic               op_take;
  // The operand being taken is the last one of the run.
  logic               last_take;

  assign start_take = start && (state_q != ACCUM);
  assign op_take    = (state_q == ACCUM) && in_valid;
  assign last_take  = op_take && (remaining_q == CNT_W'(1));

  // State register; reset returns to IDLE and aborts any run in progress.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs. A zero-length run goes straight to DONE.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (count == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_take) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = (count == '0) ? DONE : ACCUM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Accumulator and run bookkeeping. A new start clears everything the
  // display can show so a zero-length run reads back as all zeros; the
  // results of a finished run are simply held until the next start.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      sum_q       <= '0;
      remaining_q <= '0;
      accepted_q  <= '0;
      last_op_q   <= '0;
    end else if (start_take) begin
      sum_q       <= '0;
      remaining_q <= count;
      accepted_q  <= '0;
      last_op_q   <= '0;
    end else if (op_take) begin
      sum_q       <= sum_q + {{CNT_W{1'b0}}, in_data};
      remaining_q <= remaining_q - CNT_W'(1);
      accepted_q  <= accepted_q + CNT_W'(1);
      last_op_q   <= in_data;
    end
  end

  assign sum = sum_q;

  hex_digit_select u_hex_digit_select (
    .disp_sel   (disp_sel),
    .sum        (sum_q),
    .accepted   (accepted_q),
    .last_op    (last_op_q),
    .hex_digits (hex_digits)
  );

endmodule

// File: tb/tb_seq_sum_engine.sv
// Directed bench for seq_sum_engine with a done-edge scoreboard.
// Latency: inputs driven #1 after posedge; monitor samples on negedge.
// Backpressure: operands offered only while the engine is expected in ACCUM.
module tb_seq_sum_engine;
  import seq_sum_pkg::*;

  logic              clock;
  logic              resetN;
  logic              start;
  logic [CNT_W-1:0]  count;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              disp_sel;
  logic              busy;
  logic              done;
  logic [SUM_W-1:0]  sum;
  logic [HEX_W-1:0]  hex_digits;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Expected sums, one per run that should produce a rising done edge.
  logic [SUM_W-1:0] sb_q[$];
  logic             done_prev = 1'b0;
  logic             mon_en    = 1'b1;

  seq_sum_engine dut (
    .clock      (clock),
    .resetN     (resetN),
    .start      (start),
    .count      (count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .disp_sel   (disp_sel),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .hex_digits (hex_digits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of done must match the oldest expected sum.
  always @(negedge clock) begin
    if (mon_en && done && !done_prev) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 32'(sum), 32'hDEAD_BEEF);
      end else begin
        check("sb_sum", 32'(sum), 32'(sb_q.pop_front()));
      end
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] c);
    start = 1'b1;
    count = c;
    tick();
    start = 1'b0;
    count = '0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic show(input logic sel, input string name, input logic [HEX_W-1:0] exp);
    disp_sel = sel;
    #1;
    check(name, 32'(hex_digits), 32'(exp));
  endtask

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN   = 1'b0;
    start    = 1'b0;
    count    = '0;
    in_valid = 1'b0;
    in_data  = '0;
    disp_sel = 1'b0;
    repeat (3) tick();
    check("rst_done", 32'(done), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    resetN = 1'b1;
    tick();

    // Basic run: 1+2+3+4, back-to-back operands.
    sb_q.push_back(24'h00000A);
    do_start(8'd4);
    check("basic_in_ready_after_start", 32'(in_ready), 32'h1);
    check("basic_busy", 32'(busy), 32'h1);
    send(16'h0001);
    send(16'h0002);
    send(16'h0003);
    check("basic_done_before_last", 32'(done), 32'h0);
    send(16'h0004);
    check("basic_done_latency", 32'(done), 32'h1);
    check("basic_sum", 32'(sum), 32'h00000A);
    check("basic_busy_off", 32'(busy), 32'h0);
    check("basic_in_ready_off", 32'(in_ready), 32'h0);
    show(1'b1, "basic_hex_status", 24'h040004);
    show(1'b0, "basic_hex_sum", 24'h00000A);
    tick();
    check("basic_done_held", 32'(done), 32'h1);

    // Zero-length run launched from DONE: everything shown is cleared.
    do_start(8'd0);
    check("zero_done", 32'(done), 32'h1);
    check("zero_in_ready", 32'(in_ready), 32'h0);
    check("zero_sum", 32'(sum), 32'h0);
    show(1'b1, "zero_hex_status", 24'h000000);
    disp_sel = 1'b0;

    // Stalled run with start pulses in ACCUM that must be ignored.
    sb_q.push_back(24'h02FFFD);
    do_start(8'd3);
    check("stall_done_drop", 32'(done), 32'h0);
    send(16'hFFFF);
    start = 1'b1;
    count = 8'd7;
    tick();
    check("stall_in_ready_gap1a", 32'(in_ready), 32'h1);
    check("stall_sum_gap1a", 32'(sum), 32'h00FFFF);
    start = 1'b0;
    count = '0;
    tick();
    check("stall_in_ready_gap1b", 32'(in_ready), 32'h1);
    // Handshake and start in the same cycle: only the handshake counts.
    start = 1'b1;
    count = 8'd9;
    send(16'hFFFF);
    start = 1'b0;
    count = '0;
    check("stall_sum_after_2", 32'(sum), 32'h01FFFE);
    repeat (2) begin
      tick();
      check("stall_in_ready_gap2", 32'(in_ready), 32'h1);
    end
    check("stall_done_pending", 32'(done), 32'h0);
    send(16'hFFFF);
    check("stall_done", 32'(done), 32'h1);
    check("stall_sum", 32'(sum), 32'h02FFFD);
    show(1'b1, "stall_hex_status", 24'h03FFFF);
    disp_sel = 1'b0;
    tick();

    // Restart from DONE with a single operand.
    sb_q.push_back(24'h001234);
    do_start(8'd1);
    check("restart_done_drop", 32'(done), 32'h0);
    check("restart_busy", 32'(busy), 32'h1);
    send(16'h1234);
    check("restart_done", 32'(done), 32'h1);
    check("restart_sum", 32'(sum), 32'h001234);
    tick();

    // Reset mid-run after 2 of 4 operands discards the partial sum.
    do_start(8'd4);
    send(16'h0005);
    send(16'h0006);
    check("abort_partial_sum", 32'(sum), 32'h00000B);
    resetN = 1'b0;
    start  = 1'b1;
    count  = 8'd2;
    tick();
    check("abort_sum", 32'(sum), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_in_ready", 32'(in_ready), 32'h0);
    show(1'b0, "abort_hex_sum", 24'h000000);
    show(1'b1, "abort_hex_status", 24'h000000);
    disp_sel = 1'b0;
    repeat (2) tick();
    start  = 1'b0;
    count  = '0;
    resetN = 1'b1;
    tick();
    check("abort_idle_done", 32'(done), 32'h0);

    // Zero-length run from IDLE produces a done edge with a zero sum.
    sb_q.push_back(24'h000000);
    do_start(8'd0);
    check("zero_idle_done", 32'(done), 32'h1);
    check("zero_idle_in_ready", 32'(in_ready), 32'h0);
    tick();

    // Largest run: 255 operands of 0xFFFF.
    sb_q.push_back(24'hFEFF01);
    do_start(8'd255);
    for (int i = 0; i < 255; i++) begin
      send(16'hFFFF);
    end
    check("max_done", 32'(done), 32'h1);
    check("max_sum", 32'(sum), 32'hFEFF01);
    show(1'b0, "max_hex_sum", 24'hFEFF01);
    show(1'b1, "max_hex_status", 24'hFFFFFF);
    disp_sel = 1'b0;
    repeat (3) tick();

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
